// File: rtl/fifo_w2_if.sv
// fifo_w2_if: write-side handshake/status bundle of the async FIFO write stage.
// Carries wovf only when FIFO_WOVF_EN is defined.
interface fifo_w2_if #(parameter int Addr_Width = 4);
  logic                  winc;
  logic [Addr_Width:0]   wq2_rptr;
  logic [Addr_Width-1:0] waddr;
  logic [Addr_Width:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [Addr_Width:0]   wlevel;
`ifdef FIFO_WOVF_EN
  logic                  wovf;
  modport master (output winc, wq2_rptr, input waddr, wptr, wfull, walmost_full, wlevel, wovf);
  modport slave  (input winc, wq2_rptr, output waddr, wptr, wfull, walmost_full, wlevel, wovf);
`else
  modport master (output winc, wq2_rptr, input waddr, wptr, wfull, walmost_full, wlevel);
  modport slave  (input winc, wq2_rptr, output waddr, wptr, wfull, walmost_full, wlevel);
`endif
endinterface

// File: rtl/fifo_w2.sv
// fifo_w2: async FIFO write pointer, Gray pointer, full/almost-full and fill level.
// Define FIFO_WOVF_EN to add the sticky overflow flag wovf.
module fifo_w2 #(
  parameter int Addr_Width  = 4,
  parameter int Afull_Level = 14
) (
  input  logic     wclk,
  input  logic     wrst_n,
  fifo_w2_if.slave w
);
  localparam int AW = Addr_Width;
  localparam logic [AW:0] AFL = (AW+1)'(Afull_Level);
  logic [AW:0] wbin, wbin_next, wgray_next, rbin, lvl_next;
  logic accept, full_next;
  for (genvar i = 0; i <= AW; i++) begin : g_g2b
    assign rbin[i] = ^(w.wq2_rptr >> i);
  end
  always_comb begin
    accept     = w.winc & ~w.wfull;
    wbin_next  = wbin + {{AW{1'b0}}, accept};
    wgray_next = wbin_next ^ (wbin_next >> 1);
    lvl_next   = wbin_next - rbin;
    full_next  = wgray_next == {~w.wq2_rptr[AW:AW-1], w.wq2_rptr[AW-2:0]};
  end
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin           <= '0;
      w.waddr        <= '0;
      w.wptr         <= '0;
      w.wfull        <= 1'b0;
      w.walmost_full <= 1'b0;
      w.wlevel       <= '0;
    end else begin
      wbin           <= wbin_next;
      w.waddr        <= wbin_next[AW-1:0];
      w.wptr         <= wgray_next;
      w.wfull        <= full_next;
      w.walmost_full <= lvl_next >= AFL;
      w.wlevel       <= lvl_next;
    end
  end
`ifdef FIFO_WOVF_EN
  always_ff @(posedge wclk) begin
    w.wovf <= !wrst_n ? 1'b0 : (w.wovf | (w.winc & w.wfull));
  end
`endif
endmodule

// File: tb/tb_fifo_w2.sv
// tb_fifo_w2: randomized check of fifo_w2 against a write/read count model.
module tb_fifo_w2;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AFL = 14;
  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  fifo_w2_if #(.Addr_Width(AW)) w ();
  fifo_w2 #(.Addr_Width(AW), .Afull_Level(AFL)) dut (.wclk(wclk), .wrst_n(wrst_n), .w(w.slave));
  always #5 wclk = ~wclk;
  int n_cmp = 0;
  int n_bad = 0;
  int wc = 0;
  int rc = 0;
  int m_lvl = 0;
  bit m_full = 0;
  bit m_ovf = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] x;
    x = b[AW:0];
    return x ^ (x >> 1);
  endfunction
  task automatic cycle(input bit rst_n, input bit inc);
    wrst_n = rst_n;
    w.winc = inc;
    w.wq2_rptr = gray(rc);
    @(posedge wclk);
    if (!rst_n) begin
      wc = 0; m_lvl = 0; m_full = 0; m_ovf = 0;
    end else begin
      if (inc && m_full) m_ovf = 1;
      if (inc && !m_full) wc++;
      m_lvl = wc - rc;
      m_full = m_lvl == DEPTH;
    end
    #1;
    check("waddr", w.waddr, wc % DEPTH);
    check("wptr", w.wptr, gray(wc));
    check("wfull", w.wfull, m_full);
    check("walmost_full", w.walmost_full, m_lvl >= AFL);
    check("wlevel", w.wlevel, m_lvl);
`ifdef FIFO_WOVF_EN
    check("wovf", w.wovf, m_ovf);
`endif
  endtask
  initial begin
    int d1, wraps;
    logic [AW:0] pw;
    w.winc = 1'b0;
    w.wq2_rptr = '0;
    repeat (3) cycle(0, 1);
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1, 1);
      check("fill_af", w.walmost_full, i >= AFL);
    end
    check("fill_wptr", w.wptr, 5'b11000);
    check("fill_full", w.wfull, 1);
    check("fill_addr", w.waddr, 0);
    repeat (4) cycle(1, 1);
    check("ovf_wptr", w.wptr, 5'b11000);
    check("ovf_lvl", w.wlevel, 16);
    rc = 4;
    cycle(1, 0);
    check("drain_full", w.wfull, 0);
    check("drain_lvl", w.wlevel, 12);
    check("drain_af", w.walmost_full, 0);
    rc = wc;
    cycle(1, 0);
    d1 = wc;
    wraps = 0;
    pw = w.wptr;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1);
      check("wrap_lvl_le3", 32'(w.wlevel <= 3), 1);
      if (pw == 5'b10000 && w.wptr == 5'b00000) wraps++;
      pw = w.wptr;
      rc = d1;
      d1 = wc;
    end
    check("wrap_seen", wraps, 1);
    rc = 0;
    cycle(0, 0);
    repeat (10) cycle(1, 1);
    rc = 0;
    cycle(0, 1);
    check("mid_rst_addr", w.waddr, 0);
    cycle(1, 1);
    check("post_rst_addr", w.waddr, 1);
    check("post_rst_wptr", w.wptr, 5'b00001);
    for (int i = 0; i < 3000; i++) begin
      int room;
      room = wc - rc;
      if ($urandom_range(2) == 0) rc += $urandom_range(room > 2 ? 2 : room);
      if ($urandom_range(499) == 0) begin
        rc = 0;
        cycle(0, 1'($urandom));
      end else begin
        cycle(1, $urandom_range(3) != 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
